mem_sram_ctrl: RTL and testbench

//  Memory stage of the 5-stage pipeline. Sits between the EXE/MEM pipeline register and the MEM/WB register.

---
 rtl/mem_sram_ctrl_pkg.sv | 18 +
 rtl/mem_sram_ctrl_wait_cnt.sv | 29 ++
 rtl/mem_sram_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_sram_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_sram_ctrl_pkg.sv
// Shared settings for the memory-stage SRAM controller: default widths,
// the SRAM window base address and the access FSM state encoding.
package mem_sram_ctrl_pkg;

  localparam int DEF_WORD_WIDTH      = 32;
  localparam int DEF_SRAM_ADDR_WIDTH = 18;
  localparam int DEF_SRAM_DATA_WIDTH = DEF_WORD_WIDTH / 2;
  localparam int DEF_BASE_ADDR       = 1024;
  localparam int DEF_WAIT_CYCLES     = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_sram_ctrl_wait_cnt.sv
// Per-half hold counter: clears on demand, counts while enabled and flags
// the last cycle of a half access (count == WAIT_CYCLES).
module sram_wait_cnt #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign done = (count == CNT_W'(WAIT_CYCLES));

endmodule

// File: rtl/mem_sram_ctrl.sv
// Memory stage: splits each 32-bit load/store into two 16-bit accesses on an
// asynchronous SRAM and holds the pipeline (ready low) until both complete.
module mem_sram_ctrl
  import mem_sram_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH      = DEF_WORD_WIDTH,
  parameter int SRAM_ADDR_WIDTH = DEF_SRAM_ADDR_WIDTH,
  parameter int SRAM_DATA_WIDTH = DEF_SRAM_DATA_WIDTH,
  parameter int BASE_ADDR       = DEF_BASE_ADDR,
  parameter int WAIT_CYCLES     = DEF_WAIT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [WORD_WIDTH-1:0]      addr,
  input  logic [WORD_WIDTH-1:0]      wr_data,
  output logic [WORD_WIDTH-1:0]      read_data,
  output logic                       ready,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic                       sram_we_n,
  output logic [SRAM_DATA_WIDTH-1:0] sram_dq_out,
  output logic                       sram_dq_oe,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_in
);

  localparam int WA_W = SRAM_ADDR_WIDTH - 1;
  localparam int HALF = SRAM_DATA_WIDTH;

  state_t          state;
  state_t          next_state;
  logic            req;
  logic            is_read;
  logic            cnt_clear;
  logic            cnt_en;
  logic            cnt_done;
  logic [WA_W-1:0] wa;

  // A simultaneous read and write is treated as a write only.
  assign req     = mem_read | mem_write;
  assign is_read = mem_read & ~mem_write;

  // Word index inside the SRAM window; out-of-range addresses simply wrap.
  assign wa = WA_W'((addr - WORD_WIDTH'(BASE_ADDR)) >> 2);

  assign ready = ((state == IDLE) && !req) || (state == DONE);

  assign cnt_clear = (next_state != state);
  assign cnt_en    = (state == LO) || (state == HI);

  sram_wait_cnt #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_cnt (
    .clk  (clk),
    .rst  (rst),
    .clear(cnt_clear),
    .en   (cnt_en),
    .done (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // DONE always falls back to IDLE so a still-present request is not replayed.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = LO;
      LO:      if (cnt_done) next_state = HI;
      HI:      if (cnt_done) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // SRAM pins are registered from next_state so they change glitch-free
  // exactly when the FSM enters or leaves a half access.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_addr   <= '0;
      sram_we_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
      sram_dq_out <= '0;
    end else begin
      sram_addr   <= '0;
      sram_we_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
      sram_dq_out <= '0;
      if (next_state == LO) begin
        sram_addr <= {wa, 1'b0};
        if (mem_write) begin
          sram_we_n   <= 1'b0;
          sram_dq_oe  <= 1'b1;
          sram_dq_out <= wr_data[HALF-1:0];
        end
      end else if (next_state == HI) begin
        sram_addr <= {wa, 1'b1};
        if (mem_write) begin
          sram_we_n   <= 1'b0;
          sram_dq_oe  <= 1'b1;
          sram_dq_out <= wr_data[WORD_WIDTH-1:HALF];
        end
      end
    end
  end

  // Each half is sampled on its final hold cycle, once the SRAM has settled.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= '0;
    end else if (is_read && cnt_done) begin
      if (state == LO) begin
        read_data[HALF-1:0] <= sram_dq_in;
      end else if (state == HI) begin
        read_data[WORD_WIDTH-1:HALF] <= sram_dq_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Table-driven bench for mem_sram_ctrl against a behavioural async SRAM that
// commits a half-write once we_n has been held low for two cycles.
module tb_mem_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;

  int n_checks;
  int n_fail;

  mem_sram_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .wr_data    (wr_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_we_n  (sram_we_n),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: small array aliased on the low address bits, plus a log of
  // every committed half-write address.
  logic [15:0] mem [0:63];
  logic [17:0] commit_q [$];
  logic        run_active;
  logic [17:0] run_addr;
  int          run_len;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    run_active = 1'b0;
    run_addr   = '0;
    run_len    = 0;
  end

  assign sram_dq_in = mem[sram_addr[5:0]];

  always @(negedge clk) begin
    if (!sram_we_n) begin
      if (run_active && sram_addr == run_addr) begin
        run_len = run_len + 1;
      end else begin
        run_active = 1'b1;
        run_addr   = sram_addr;
        run_len    = 1;
      end
      if (run_len == 2) begin
        mem[sram_addr[5:0]] = sram_dq_out;
        commit_q.push_back(sram_addr);
      end
    end else begin
      run_active = 1'b0;
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_commits;
    logic [17:0] exp_lo;
  } vec_t;

  vec_t vecs [8];

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] d);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wr_data   = d;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives one access starting now and returns the cycle index where ready
  // first rises (-1 if it never does); returns at the negedge of that cycle.
  task automatic runTxn(input vec_t v, output int lat);
    applyStimulus(v.rd, v.wr, v.addr, v.wdata);
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ready) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lat;
    int base;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

    vecs[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h00000000, 2, 18'd2};
    vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h00000000, 32'hDEADBEEF, 0, 18'd2};
    vecs[2] = '{1'b0, 1'b1, 32'd1040, 32'hCAFE1234, 32'hDEADBEEF, 2, 18'd8};
    vecs[3] = '{1'b1, 1'b0, 32'd1040, 32'h00000000, 32'hCAFE1234, 0, 18'd8};
    vecs[4] = '{1'b1, 1'b1, 32'd1024, 32'hA5A55A5A, 32'hCAFE1234, 2, 18'd0};
    vecs[5] = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 32'hA5A55A5A, 0, 18'd0};
    vecs[6] = '{1'b0, 1'b1, 32'd1020, 32'h0BADF00D, 32'hA5A55A5A, 2, 18'h3FFFE};
    vecs[7] = '{1'b1, 1'b0, 32'd1020, 32'h00000000, 32'h0BADF00D, 0, 18'h3FFFE};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle_ready", 32'(ready), 32'd1);
      checkOutput("idle_we_n", 32'(sram_we_n), 32'd1);
      checkOutput("idle_oe", 32'(sram_dq_oe), 32'd0);
      checkOutput("idle_read_data", read_data, 32'h0);
      checkOutput("idle_sram_addr", 32'(sram_addr), 32'h0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      base = commit_q.size();
      runTxn(vecs[i], lat);
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'd5);
      checkOutput($sformatf("v%0d_read_data", i), read_data, vecs[i].exp_rdata);
      checkOutput($sformatf("v%0d_commits", i), 32'(commit_q.size() - base),
                  32'(vecs[i].exp_commits));
      if (vecs[i].wr) begin
        if (commit_q.size() > base + 1) begin
          checkOutput($sformatf("v%0d_lo_addr", i), 32'(commit_q[base]), 32'(vecs[i].exp_lo));
          checkOutput($sformatf("v%0d_hi_addr", i), 32'(commit_q[base + 1]),
                      32'(vecs[i].exp_lo | 18'd1));
        end
        checkOutput($sformatf("v%0d_mem_lo", i), 32'(mem[vecs[i].exp_lo[5:0]]),
                    32'(vecs[i].wdata[15:0]));
        checkOutput($sformatf("v%0d_mem_hi", i), 32'(mem[vecs[i].exp_lo[5:0] | 6'd1]),
                    32'(vecs[i].wdata[31:16]));
      end
      @(posedge clk);
      #1;
    end

    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hold_read_data", read_data, 32'h0BADF00D);
      checkOutput("hold_ready", 32'(ready), 32'd1);
      checkOutput("hold_we_n", 32'(sram_we_n), 32'd1);
      @(posedge clk);
      #1;
    end

    // Reset lands on the first HI cycle of a write: only the low half lands.
    base = commit_q.size();
    applyStimulus(1'b0, 1'b1, 32'd1032, 32'h12345678);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_hi_sram_addr", 32'(sram_addr), 32'd5);
    checkOutput("rst_hi_we_n", 32'(sram_we_n), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_read_data", read_data, 32'h0);
    checkOutput("rst_we_n", 32'(sram_we_n), 32'd1);
    checkOutput("rst_oe", 32'(sram_dq_oe), 32'd0);
    checkOutput("rst_sram_addr", 32'(sram_addr), 32'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_commits", 32'(commit_q.size() - base), 32'd1);
    if (commit_q.size() > base) begin
      checkOutput("rst_commit_addr", 32'(commit_q[base]), 32'd4);
    end
    checkOutput("rst_mem4", 32'(mem[4]), 32'h5678);
    checkOutput("rst_mem5", 32'(mem[5]), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
